// File: rtl/patgen_pkg.sv
// Shared types and helpers for the pattern_pulse_gen serial pulse-pattern generator.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL = 1'b0;

  // Requested lengths beyond the pattern register are clamped to its width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_pulse_gen_bit_timer.sv
// bit_timer: loadable down-counter giving a one-cycle expire strobe after max(ticks,1) cycles.
module bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] ticks,
  output logic             expire
);

  logic [DIV_W-1:0] count;
  logic             armed;

  // A zero tick count behaves like one so a bit is never skipped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= (ticks == '0) ? '0 : ticks - DIV_W'(1);
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - DIV_W'(1);
    end
  end

  assign expire = armed && (count == '0);

endmodule

// File: rtl/pattern_pulse_gen.sv
// Serial pulse-pattern generator: emits a latched pattern LSB first, one-shot or repeating.
// Optional inter-pass gap enabled by defining PATGEN_GAP_EN (adds gap_ticks port and GAP state).
module pattern_pulse_gen
  import patgen_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DIV_W = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [DIV_W-1:0] bit_ticks,
  input  logic             repeat_mode,
`ifdef PATGEN_GAP_EN
  input  logic [DIV_W-1:0] gap_ticks,
`endif
  input  logic             stop,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_index
);

  state_t           state;
  logic [WIDTH-1:0] pat_lat;
  logic [LEN_W-1:0] len_lat;
  logic [DIV_W-1:0] ticks_lat;
  logic             rep_lat;
  logic             stop_pending;
`ifdef PATGEN_GAP_EN
  logic [DIV_W-1:0] gap_lat;
`endif

  logic             expire;
  logic             timer_load;
  logic [DIV_W-1:0] timer_ticks;
  logic             start_ok;
  logic             last_bit;
  logic             stop_req;
  logic [LEN_W-1:0] next_idx;

  // A start in the done cycle is dropped so the earliest restart is one cycle later.
  assign start_ok = start && (length != '0) && !done;
  assign last_bit = (bit_index == len_lat - LEN_W'(1));
  assign stop_req = stop_pending || stop;
  assign next_idx = bit_index + LEN_W'(1);

  always_comb begin
    timer_load  = 1'b0;
    timer_ticks = ticks_lat;
    case (state)
      IDLE: begin
        if (start_ok) begin
          timer_load  = 1'b1;
          timer_ticks = bit_ticks;
        end
      end
      RUN: begin
        if (expire) begin
          if (!last_bit) begin
            timer_load = 1'b1;
          end else if (rep_lat && !stop_req) begin
            timer_load = 1'b1;
`ifdef PATGEN_GAP_EN
            if (gap_lat != '0) timer_ticks = gap_lat;
`endif
          end
        end
      end
`ifdef PATGEN_GAP_EN
      GAP: begin
        if (expire && !stop_req) timer_load = 1'b1;
      end
`endif
      default: begin
        timer_load = 1'b0;
      end
    endcase
  end

  bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .ticks   (timer_ticks),
    .expire  (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pat_lat      <= '0;
      len_lat      <= '0;
      ticks_lat    <= '0;
      rep_lat      <= 1'b0;
      stop_pending <= 1'b0;
`ifdef PATGEN_GAP_EN
      gap_lat      <= '0;
`endif
      signal       <= IDLE_LEVEL;
      busy         <= 1'b0;
      done         <= 1'b0;
      bit_index    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (start_ok) begin
            pat_lat   <= pattern;
            len_lat   <= LEN_W'(clamp_len(int'(length), WIDTH));
            ticks_lat <= bit_ticks;
            rep_lat   <= repeat_mode;
`ifdef PATGEN_GAP_EN
            gap_lat   <= gap_ticks;
`endif
            signal    <= pattern[0];
            busy      <= 1'b1;
            bit_index <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (expire) begin
            if (!last_bit) begin
              bit_index <= next_idx;
              signal    <= pat_lat[next_idx];
            end else if (rep_lat && !stop_req) begin
              bit_index <= '0;
`ifdef PATGEN_GAP_EN
              if (gap_lat != '0) begin
                signal <= IDLE_LEVEL;
                state  <= GAP;
              end else begin
                signal <= pat_lat[0];
              end
`else
              signal <= pat_lat[0];
`endif
            end else begin
              state        <= IDLE;
              signal       <= IDLE_LEVEL;
              busy         <= 1'b0;
              done         <= 1'b1;
              bit_index    <= '0;
              stop_pending <= 1'b0;
            end
          end
        end
`ifdef PATGEN_GAP_EN
        GAP: begin
          if (stop) stop_pending <= 1'b1;
          if (expire) begin
            if (stop_req) begin
              state        <= IDLE;
              signal       <= IDLE_LEVEL;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
            end else begin
              state  <= RUN;
              signal <= pat_lat[0];
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_pulse_gen.sv
// Self-checking bench for pattern_pulse_gen: queue-based waveform model plus directed literal checks.
module tb_pattern_pulse_gen;

  localparam int WIDTH = 11;
  localparam int DIV_W = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic [DIV_W-1:0] bit_ticks;
  logic             repeat_mode;
  logic             stop;
  logic             signal;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_index;
`ifdef PATGEN_GAP_EN
  logic [DIV_W-1:0] gap_ticks = '0;
`endif

  int total = 0;
  int bad   = 0;

  pattern_pulse_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .pattern     (pattern),
    .length      (length),
    .bit_ticks   (bit_ticks),
    .repeat_mode (repeat_mode),
`ifdef PATGEN_GAP_EN
    .gap_ticks   (gap_ticks),
`endif
    .stop        (stop),
    .signal      (signal),
    .busy        (busy),
    .done        (done),
    .bit_index   (bit_index)
  );

  always #5 clock = ~clock;

  // Model: every upcoming output cycle of the current pass is queued as (level, index).
  typedef struct {
    logic s;
    int   idx;
  } step_t;

  step_t            q[$];
  logic             m_active = 1'b0;
  logic             m_stop   = 1'b0;
  logic             m_done   = 1'b0;
  logic             m_rep    = 1'b0;
  logic [WIDTH-1:0] m_pat    = '0;
  int               m_len    = 0;
  int               m_ticks  = 1;
  logic             prev_done;

  task automatic build_pass();
    for (int b = 0; b < m_len; b++)
      for (int t = 0; t < m_ticks; t++)
        q.push_back('{m_pat[b], b});
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_active = 1'b0;
      m_stop   = 1'b0;
      m_done   = 1'b0;
    end else begin
      prev_done = m_done;
      m_done    = 1'b0;
      if (m_active) begin
        if (stop) m_stop = 1'b1;
        void'(q.pop_front());
        if (q.size() == 0) begin
          if (m_rep && !m_stop) begin
            build_pass();
          end else begin
            m_active = 1'b0;
            m_stop   = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (start && length != 0 && !prev_done) begin
        m_pat   = pattern;
        m_len   = (int'(length) > WIDTH) ? WIDTH : int'(length);
        m_ticks = (bit_ticks == 0) ? 1 : int'(bit_ticks);
        m_rep   = repeat_mode;
        build_pass();
        m_active = 1'b1;
      end
    end
  end

  function automatic int model_sig();
    return (m_active && q.size() > 0) ? int'(q[0].s) : 0;
  endfunction

  function automatic int model_idx();
    return (m_active && q.size() > 0) ? q[0].idx : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  logic chk_en = 1'b0;

  always @(negedge clock) begin
    if (reset_n && chk_en) begin
      checkOutput("signal", int'(signal), model_sig());
      checkOutput("busy", int'(busy), int'(m_active));
      checkOutput("done", int'(done), int'(m_done));
      checkOutput("bit_index", int'(bit_index), model_idx());
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] p, input int len, input int ticks, input logic rep);
    pattern     = p;
    length      = LEN_W'(len);
    bit_ticks   = DIV_W'(ticks);
    repeat_mode = rep;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  logic [23:0] cap_sig, cap_busy, cap_done, cap_msig;
  int cnt;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    pattern = 11'h7FF; length = 4'd5; bit_ticks = 8'd1; repeat_mode = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      start = ~start;
    end
    tick();
    checkOutput("reset_signal", int'(signal), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    start   = 1'b0;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (3) tick();
    checkOutput("idle_busy", int'(busy), 0);

    // One-shot 0x2AA, two cycles per bit, with mid-run interference and a start on done.
    applyStimulus(11'h2AA, 11, 2, 1'b0);
    for (int k = 0; k < 24; k++) begin
      cap_sig[k]  = signal;
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_msig[k] = model_sig() != 0;
      if (k == 4)  begin pattern = 11'h7FF; start = 1'b1; end
      if (k == 5)  start = 1'b0;
      if (k == 22) start = 1'b1;
      if (k == 23) start = 1'b0;
      tick();
    end
    checkOutput("oneshot_sig", int'(cap_sig), 24'h0CCCCC);
    checkOutput("oneshot_busy", int'(cap_busy), 24'h3FFFFF);
    checkOutput("oneshot_done", int'(cap_done), 24'h400000);
    checkOutput("oneshot_model", int'(cap_msig), 24'h0CCCCC);

    // Repeat of 4'b1101 with a stop pulse in the second pass.
    cap_sig = '0; cap_busy = '0; cap_done = '0; cap_msig = '0;
    applyStimulus(11'b1101, 4, 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cap_sig[k]  = signal;
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_msig[k] = model_sig() != 0;
      if (k == 5) stop = 1'b1;
      if (k == 6) stop = 1'b0;
      tick();
    end
    checkOutput("repeat_sig", int'(cap_sig), 24'h0000DD);
    checkOutput("repeat_busy", int'(cap_busy), 24'h0000FF);
    checkOutput("repeat_done", int'(cap_done), 24'h000100);
    checkOutput("repeat_model", int'(cap_msig), 24'h0000DD);

    applyStimulus(11'h155, 0, 1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cnt += int'(busy) + int'(done);
      tick();
    end
    checkOutput("len0_activity", cnt, 0);

    applyStimulus(11'h5A3, 15, 1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cnt += int'(busy);
      tick();
    end
    checkOutput("len15_busy_cycles", cnt, 11);

    applyStimulus(11'b101, 3, 0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cnt += int'(busy);
      tick();
    end
    checkOutput("ticks0_busy_cycles", cnt, 3);

    // Asynchronous reset while bit 5 is on the line.
    applyStimulus(11'h3E0, 11, 1, 1'b0);
    repeat (5) tick();
    checkOutput("pre_reset_sig", int'(signal), 1);
    checkOutput("pre_reset_idx", int'(bit_index), 5);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_signal", int'(signal), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_done", int'(done), 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checkOutput("post_reset_done", int'(done), 0);

    for (int c = 0; c < 2000; c++) begin
      pattern     = WIDTH'($urandom);
      length      = LEN_W'($urandom_range(0, 15));
      bit_ticks   = DIV_W'($urandom_range(0, 3));
      repeat_mode = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b0;
    stop  = 1'b1;
    repeat (100) tick();
    stop = 1'b0;
    tick();
    checkOutput("drain_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_pulse_gen.md
Name: pattern_pulse_gen

Overview:
Synthesizable, parametrised serial pulse-pattern generator, the clocked successor to the testbench pulse generators driven by the clock module.
- Serializes a programmable WIDTH-bit pattern, LSB first, onto one output line.
- Each bit is held for a programmable number of clock cycles.
- Runs one-shot or repeating, with start/busy/done handshake and graceful stop.
- Used as a stimulus source and waveform generator in lab exercises and on-chip test.

Parameters:
WIDTH, 11, maximum pattern length in bits
DIV_W, 8, width of bit-time divider (cycles per bit up to 2^DIV_W-1)
LEN_W, $clog2(WIDTH+1), width of length field

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin pattern; sampled only in IDLE
pattern  input  WIDTH  bit pattern, bit 0 emitted first
length  input  LEN_W  number of bits to emit
bit_ticks  input  DIV_W  clock cycles per bit; 0 treated as 1
repeat_mode  input  1  1 = loop pattern until stop
stop  input  1  request graceful stop at end of current pass
signal  output  1  serial pattern output, registered
busy  output  1  high while a pattern is being emitted
done  output  1  one-cycle pulse when generator returns to IDLE
bit_index  output  LEN_W  index of bit currently on signal

Behaviour:
- Single clock domain: clock. reset_n is asynchronous, active-low.
- Reset values: signal=0, busy=0, done=0, bit_index=0, FSM=IDLE, all latched config cleared, stop_pending=0.
- Reset asserted mid-pattern aborts immediately to reset values. No done pulse.
- States: IDLE, RUN; GAP when PATGEN_GAP_EN is defined.
- IDLE, start=1, length!=0: latch pattern, bit_ticks, repeat_mode.
  - Latch effective length = min(length, WIDTH).
  - Next cycle: signal=pattern[0], busy=1, bit_index=0, FSM=RUN.
  - Latency from start sample to first bit is one cycle.
- IDLE, start=1, length=0: ignored. No busy, no done.
- RUN: each bit is held for max(bit_ticks,1) cycles, timed by a down-counter.
  - On bit expiry with bit_index < len-1: increment bit_index and drive pattern[bit_index+1].
- End of pass (last bit expires), repeat_mode=1 and no stop pending: bit_index=0, signal=pattern[0] on the next cycle, with no idle cycle in between.
- End of pass, repeat_mode=0 or stop pending: next cycle signal=0, busy=0, done=1 for exactly one cycle, FSM=IDLE.
- stop is sticky: a one-cycle pulse during RUN sets stop_pending. It is cleared on return to IDLE.
  - stop never truncates a pass.
  - stop in IDLE is ignored.
- start while busy is ignored. Config input changes while busy have no effect, because latched copies are used.
- start in the same cycle as done: ignored. Earliest restart is the cycle after done.
- bit_ticks=1, len=1, repeat: signal is constant pattern[0] and busy stays 1.

Optional Feature:
PATGEN_GAP_EN
- Defined: adds input gap_ticks[DIV_W] and state GAP.
  - Between repeat passes, signal=0 for gap_ticks cycles, busy stays 1, bit_index=0.
  - gap_ticks=0 skips GAP entirely.
  - stop during GAP goes to IDLE at GAP expiry, with done pulse.
- Undefined: no gap_ticks port, no GAP state, passes are back-to-back.

Decomposition:
- Package patgen_pkg holds:
  - state enum (IDLE, RUN, GAP)
  - IDLE_LEVEL constant = 1'b0
  - helper function for the effective-length clamp
- Sub-module bit_timer (DIV_W): loadable down-counter.
  - Inputs: clock, reset_n, load, ticks.
  - Output: one-cycle expire strobe.
  - Instantiated once; reused for GAP timing.

Test Plan:
- Reset: hold reset_n=0 while toggling start -> signal=0, busy=0, done=0. Release; outputs unchanged until start.
- One-shot: pattern=11'b01010_101010 (0x2AA), length=11, bit_ticks=2, repeat_mode=0, start pulse.
  - signal follows LSB-first 0,1,0,1,... with each bit held 2 cycles.
  - busy for 22 cycles, then done for 1 cycle, signal=0.
- Repeat + stop: pattern=4'b1101, length=4, bit_ticks=1, repeat_mode=1. Pulse stop in cycle 6.
  - Output is 1,0,1,1,1,0,1,1 with no gap.
  - done is asserted the cycle after bit 7.
- Boundaries: length=0 with start -> no busy/done. length=15 with WIDTH=11 -> exactly 11 bits emitted. bit_ticks=0 -> behaves as 1.
- Busy interlock: second start and changed pattern mid-run -> original pattern completes unaltered. start coincident with done ignored.
- Async reset mid-run in bit 5 -> immediate signal=0, busy=0, no done pulse. Next start runs normally.
- (PATGEN_GAP_EN) gap_ticks=3, repeat of 2-bit pattern 2'b11 -> 1,1,0,0,0,1,1, with busy held high throughout.
